// File: rtl/vga_text_pkg.sv
// Shared types and ASCII constants for the VGA text terminal.
package vga_text_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        SCROLL = 2'd2
    } term_state_e;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] PRINT_MIN   = 8'h20;
    localparam logic [7:0] PRINT_MAX   = 8'h7E;

endpackage

// File: rtl/vga_font_rom.sv
// Glyph ROM with registered, qualified pixel-bit read (second pixel pipeline stage).
// Procedural font: row y of glyph c is c ^ (5*y), truncated to CHAR_W bits.
module vga_font_rom #(
    parameter int unsigned CHAR_W = 9,
    parameter int unsigned CHAR_H = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                ch,
    input  logic [$clog2(CHAR_H)-1:0] y,
    input  logic [$clog2(CHAR_W)-1:0] x,
    input  logic                      en,
    input  logic                      invert,
    output logic                      pix
);
    localparam int unsigned XW = $clog2(CHAR_W);

    logic [CHAR_W-1:0] row_bits;
    logic              bit_c;

    assign row_bits = CHAR_W'(ch) ^ CHAR_W'(32'(y) * 32'd5);
    // MSB of a glyph row is the leftmost pixel
    assign bit_c    = row_bits[XW'(CHAR_W - 1) - x];

    always_ff @(posedge clk) begin
        if (rst) pix <= 1'b0;
        else     pix <= en & (bit_c ^ invert);
    end

endmodule

// File: rtl/vga_text_term.sv
// VGA text terminal: char buffer with cursor, LF/CR/BS handling, hardware scroll and 2-stage pixel path.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
module vga_text_term
    import vga_text_pkg::*;
#(
    parameter int unsigned COLS      = 70,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned CHAR_W    = 9,
    parameter int unsigned CHAR_H    = 16,
    parameter logic [23:0] FG        = 24'hFFFFFF,
    parameter logic [23:0] BG        = 24'h000000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ch_valid,
    input  logic [7:0]                ch_data,
    output logic                      ch_ready,
    input  logic [9:0]                h_addr,
    input  logic [9:0]                v_addr,
    output logic [23:0]               vga_data,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic [$clog2(ROWS)-1:0]   cur_row,
    output logic                      busy
);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned AW    = $clog2(CELLS);
    localparam int unsigned XW    = $clog2(CHAR_W);
    localparam int unsigned YW    = $clog2(CHAR_H);

    localparam logic [1:0] ST_CLEAR  = CLEAR;
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SCROLL = SCROLL;

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [RW-1:0] row, row_nxt;
    logic          line_feed;

    logic [7:0]    mem [CELLS];
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] scroll_addr;
    logic [7:0]    scroll_rd;
    logic          printable;

    assign cur_addr    = AW'(row) * AW'(COLS) + AW'(col);
    assign scroll_addr = (cnt < AW'(CELLS - COLS)) ? cnt + AW'(COLS) : cnt;
    assign scroll_rd   = mem[scroll_addr];
    assign printable   = (ch_data >= PRINT_MIN) && (ch_data <= PRINT_MAX);

    // Next state, cursor update and the single char RAM write port
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        col_nxt   = col;
        row_nxt   = row;
        line_feed = 1'b0;
        we        = 1'b0;
        waddr     = cnt;
        wdata     = ASCII_SPACE;
        case (state)
            ST_CLEAR, ST_SCROLL: begin
                we = 1'b1;
                if (state == ST_SCROLL && cnt < AW'(CELLS - COLS)) wdata = scroll_rd;
                if (cnt == AW'(CELLS - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            ST_IDLE: begin
                if (ch_valid) begin
                    if (printable) begin
                        we    = 1'b1;
                        waddr = cur_addr;
                        wdata = ch_data;
                        if (col == CW'(COLS - 1)) begin
                            col_nxt   = '0;
                            line_feed = 1'b1;
                        end else begin
                            col_nxt = col + CW'(1);
                        end
                    end else if (ch_data == ASCII_LF) begin
                        col_nxt   = '0;
                        line_feed = 1'b1;
                    end else if (ch_data == ASCII_CR) begin
                        col_nxt = '0;
                    end else if (ch_data == ASCII_BS) begin
                        // Both backspace cases erase the cell just before the cursor in linear order
                        if (col != '0) begin
                            col_nxt = col - CW'(1);
                            we      = 1'b1;
                            waddr   = cur_addr - AW'(1);
                        end else if (row != '0) begin
                            row_nxt = row - RW'(1);
                            col_nxt = CW'(COLS - 1);
                            we      = 1'b1;
                            waddr   = cur_addr - AW'(1);
                        end
                    end
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
        if (line_feed) begin
            if (row == RW'(ROWS - 1)) state_nxt = ST_SCROLL;
            else                      row_nxt   = row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) mem[waddr] <= wdata;
    end

    assign ch_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign cur_col  = col;
    assign cur_row  = row;

    // Pixel stage 1: cell coordinates, glyph offsets and in-area flag
    logic [9:0]    h_cell, v_cell;
    logic          in_area;
    logic          cursor_inv;
    logic [CW-1:0] s1_col;
    logic [RW-1:0] s1_row;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;
    logic          s1_in;
    logic          s1_inv;
    logic [7:0]    disp_ch;
    logic          pix;

    assign h_cell  = h_addr / 10'(CHAR_W);
    assign v_cell  = v_addr / 10'(CHAR_H);
    assign in_area = (h_cell < 10'(COLS)) && (v_cell < 10'(ROWS));

`ifdef CURSOR_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign cursor_inv = phase && (state == ST_IDLE) && in_area &&
                        (h_cell == 10'(col)) && (v_cell == 10'(row));
`else
    assign cursor_inv = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_col <= '0;
            s1_row <= '0;
            s1_x   <= '0;
            s1_y   <= '0;
            s1_in  <= 1'b0;
            s1_inv <= 1'b0;
        end else begin
            s1_col <= in_area ? CW'(h_cell) : '0;
            s1_row <= in_area ? RW'(v_cell) : '0;
            s1_x   <= XW'(h_addr % 10'(CHAR_W));
            s1_y   <= YW'(v_addr % 10'(CHAR_H));
            s1_in  <= in_area;
            s1_inv <= cursor_inv;
        end
    end

    // Pixel stage 2: display read port feeds the registered font lookup
    assign disp_ch = mem[AW'(s1_row) * AW'(COLS) + AW'(s1_col)];

    vga_font_rom #(
        .CHAR_W (CHAR_W),
        .CHAR_H (CHAR_H)
    ) u_font (
        .clk    (clk),
        .rst    (rst),
        .ch     (disp_ch),
        .y      (s1_y),
        .x      (s1_x),
        .en     (s1_in),
        .invert (s1_inv),
        .pix    (pix)
    );

    assign vga_data = pix ? FG : BG;

endmodule

// File: tb/tb_vga_text_term.sv
// Self-checking bench for vga_text_term: cursor vector table, hand sequences and random byte stream vs a screen model.
module tb_vga_text_term;
    localparam int COLS      = 8;
    localparam int ROWS      = 4;
    localparam int CHAR_W    = 9;
    localparam int CHAR_H    = 16;
    localparam int BLINK_DIV = 40;
    localparam int N         = COLS * ROWS;
    localparam int BOUND     = 4 * N + 100;
    localparam logic [23:0] FG = 24'hF0E0D0;
    localparam logic [23:0] BG = 24'h102030;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ch_valid = 1'b0;
    logic [7:0]  ch_data = 8'h00;
    logic        ch_ready;
    logic [9:0]  h_addr = '0;
    logic [9:0]  v_addr = '0;
    logic [23:0] vga_data;
    logic [2:0]  cur_col;
    logic [1:0]  cur_row;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] scr [ROWS][COLS];
    int mcol, mrow;
    int ph[$];
    int pv[$];

    always #5 clk = ~clk;

    vga_text_term #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H),
        .FG(FG), .BG(BG), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .h_addr(h_addr), .v_addr(v_addr), .vga_data(vga_data),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

`ifdef CURSOR_BLINK_EN
    int nclk = 0;
    always @(posedge clk) begin
        if (rst) nclk <= 0;
        else     nclk <= nclk + 1;
    end
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int glyph(input int c, input int y);
        return (c ^ (y * 5)) & 'h1FF;
    endfunction

    function automatic logic [23:0] exp_pixel(input int h, input int v);
        int c, r, x, y, b, inv;
        c = h / CHAR_W;
        r = v / CHAR_H;
        x = h % CHAR_W;
        y = v % CHAR_H;
        if (c >= COLS || r >= ROWS) return BG;
        b = (glyph(int'(scr[r][c]), y) >> (CHAR_W - 1 - x)) & 1;
        inv = 0;
`ifdef CURSOR_BLINK_EN
        if (r == mrow && c == mcol && ((nclk / BLINK_DIV) % 2) == 0) inv = 1;
`endif
        return ((b ^ inv) != 0) ? FG : BG;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
        mcol = 0;
        mrow = 0;
    endtask

    task automatic model_apply(input logic [7:0] c, output bit scrolled);
        bit nl = 0;
        scrolled = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            scr[mrow][mcol] = c;
            mcol++;
            if (mcol == COLS) begin mcol = 0; nl = 1; end
        end else if (c == 8'h0A) begin
            mcol = 0; nl = 1;
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h08) begin
            if (mcol > 0) begin
                mcol--; scr[mrow][mcol] = 8'h20;
            end else if (mrow > 0) begin
                mrow--; mcol = COLS - 1; scr[mrow][mcol] = 8'h20;
            end
        end
        if (nl) begin
            if (mrow == ROWS - 1) begin
                for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r + 1];
                for (int k = 0; k < COLS; k++) scr[ROWS - 1][k] = 8'h20;
                scrolled = 1;
            end else begin
                mrow++;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted
    task automatic send(input logic [7:0] c, output bit scrolled);
        int n = 0;
        while (!ch_ready && n < BOUND) begin @(negedge clk); n++; end
        if (!ch_ready) chk("send_ready", 32'(ch_ready), 32'd1);
        ch_valid = 1'b1;
        ch_data  = c;
        @(negedge clk);
        ch_valid = 1'b0;
        model_apply(c, scrolled);
    endtask

    task automatic send_seq(input logic [7:0] c);
        bit s;
        send(c, s);
        if (s) wait_idle("scroll_len");
    endtask

    // Counts busy cycles from the current negedge until ch_ready returns
    task automatic wait_idle(input string name);
        int n = 0;
        while (!ch_ready && n < BOUND) begin n++; @(negedge clk); end
        chk(name, 32'(n), 32'(N));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_idle("clear_len");
    endtask

    task automatic chk_cursor(input string name, input int c, input int r);
        chk({name, "_col"}, 32'(cur_col), 32'(c));
        chk({name, "_row"}, 32'(cur_row), 32'(r));
    endtask

    // Streams queued probe addresses one per cycle, comparing vga_data two cycles later
    task automatic run_stream(input string name);
        logic [23:0] eq[$];
        int n = ph.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) chk(name, 32'(vga_data), 32'(eq.pop_front()));
            if (i < n) begin
                h_addr = 10'(ph[i]);
                v_addr = 10'(pv[i]);
                eq.push_back(exp_pixel(ph[i], pv[i]));
            end
        end
        ph.delete();
        pv.delete();
    endtask

    task automatic add_cell_full(input int r, input int c);
        for (int y = 0; y < CHAR_H; y++)
            for (int x = 0; x < CHAR_W; x++) begin
                ph.push_back(c * CHAR_W + x);
                pv.push_back(r * CHAR_H + y);
            end
    endtask

    task automatic screen_check(input string name);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                int y = int'($urandom_range(CHAR_H - 1, 0));
                for (int x = 0; x < CHAR_W; x++) begin
                    ph.push_back(c * CHAR_W + x);
                    pv.push_back(r * CHAR_H + y);
                end
            end
        for (int k = 0; k < 4; k++) begin
            ph.push_back(COLS * CHAR_W + int'($urandom_range(200, 0)));
            pv.push_back(int'($urandom_range(ROWS * CHAR_H - 1, 0)));
            ph.push_back(int'($urandom_range(COLS * CHAR_W - 1, 0)));
            pv.push_back(ROWS * CHAR_H + int'($urandom_range(200, 0)));
        end
        run_stream(name);
    endtask

    typedef struct {
        logic [7:0] ch;
        int         col;
        int         row;
    } vec_t;

    vec_t vt[14];

    initial begin
        bit s;
        logic [7:0] b;

        vt[0]  = '{8'h41, 1, 0};
        vt[1]  = '{8'h42, 2, 0};
        vt[2]  = '{8'h07, 2, 0};
        vt[3]  = '{8'h0D, 0, 0};
        vt[4]  = '{8'h08, 0, 0};
        vt[5]  = '{8'h43, 1, 0};
        vt[6]  = '{8'h08, 0, 0};
        vt[7]  = '{8'h0A, 0, 1};
        vt[8]  = '{8'h08, 7, 0};
        vt[9]  = '{8'h58, 0, 1};
        vt[10] = '{8'h0A, 0, 2};
        vt[11] = '{8'h0A, 0, 3};
        vt[12] = '{8'h44, 1, 3};
        vt[13] = '{8'hFF, 1, 3};

        // Reset and initial clear
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(ch_ready), 32'd0);
        chk_cursor("rst", 0, 0);
        chk("rst_vga", 32'(vga_data), 32'(BG));
        rst = 1'b0;
        model_reset();
        wait_idle("clear_len");
        chk("idle_busy", 32'(busy), 32'd0);
        screen_check("clear_screen");

        // "AB" and a full glyph probe
        send_seq(8'h41);
        send_seq(8'h42);
        chk_cursor("ab", 2, 0);
        add_cell_full(0, 0);
        add_cell_full(0, 1);
        run_stream("ab_glyph");

        // Cursor vector table
        do_reset();
        for (int i = 0; i < 14; i++) begin
            send_seq(vt[i].ch);
            chk_cursor($sformatf("vec%0d", i), vt[i].col, vt[i].row);
        end
        screen_check("vec_screen");

        // Full row wrap then 'Z'
        do_reset();
        for (int i = 0; i < COLS; i++) send_seq(8'($urandom_range(8'h7E, 8'h20)));
        send_seq(8'h5A);
        chk_cursor("wrap", 1, 1);
        screen_check("wrap_screen");

        // LF on last row scrolls the buffer
        do_reset();
        for (int i = 0; i < 3 * COLS + 5; i++) send_seq(8'($urandom_range(8'h7E, 8'h21)));
        chk_cursor("pre_scroll", 5, ROWS - 1);
        send(8'h0A, s);
        chk("scroll_flag", 32'(s), 32'd1);
        chk("scroll_ready", 32'(ch_ready), 32'd0);
        wait_idle("scroll_len");
        chk_cursor("post_scroll", 0, ROWS - 1);
        screen_check("scroll_screen");

        // Backspace corners and ignored control byte
        do_reset();
        send_seq(8'h51);
        send_seq(8'h0D);
        send_seq(8'h08);
        chk_cursor("bs_origin", 0, 0);
        send_seq(8'h0A);
        for (int i = 0; i < COLS; i++) send_seq(8'h52 + 8'(i));
        chk_cursor("bs_pre", 0, 2);
        send_seq(8'h08);
        chk_cursor("bs_wrap", COLS - 1, 1);
        send_seq(8'h07);
        chk_cursor("bel", COLS - 1, 1);
        screen_check("bs_screen");

        // Reset in the middle of a scroll
        for (int i = 0; i < 2; i++) send_seq(8'h0A);
        send(8'h0A, s);
        chk("mid_scroll_flag", 32'(s), 32'd1);
        repeat (10) @(negedge clk);
        chk("mid_scroll_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_ready", 32'(ch_ready), 32'd0);
        chk_cursor("abort", 0, 0);
        rst = 1'b0;
        model_reset();
        wait_idle("abort_clear_len");
        screen_check("abort_screen");

        // Random byte stream against the model
        for (int i = 0; i < 200; i++) begin
            int p = int'($urandom_range(99, 0));
            if      (p < 70) b = 8'($urandom_range(8'h7E, 8'h20));
            else if (p < 80) b = 8'h0A;
            else if (p < 85) b = 8'h0D;
            else if (p < 93) b = 8'h08;
            else             b = 8'($urandom_range(255, 0));
            send(b, s);
            if (s) wait_idle("rand_scroll_len");
            chk_cursor("rand", mcol, mrow);
            if (i % 40 == 39) screen_check("rand_screen");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
